// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment scanner: stb/ack value intake, per-digit dwell with blanking gap,
// and frame-boundary display updates. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module seven_segment_scan #(
    parameter int         DIGITS       = 8,
    parameter int         SCAN_DIV     = 100000,
    parameter int         BLANK_CYCLES = 2,
    parameter logic [7:0] DP_MASK      = 8'h00,
    parameter bit         ACTIVE_LOW   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       input_value,
    input  logic              input_value_stb,
    output logic              input_value_ack,
    output logic [DIGITS-1:0] output_annode,
    output logic [7:0]        output_cathode
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW    = 4 * DIGITS;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0]  BLANK_LIM = PRE_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ANODE_OFF = ACTIVE_LOW ? '1 : '0;
    localparam logic [7:0]        CATH_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;

    // Handshake: a transfer happens on a clock edge where stb && ack; stb is held until ack,
    // ack is high for exactly one cycle, and no new ack is issued while a value is pending.
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ACK     = 2'b01,
        S_PENDING = 2'b10
    } hs_state_t;

    hs_state_t         state, state_next;
    logic              pending;
    logic [PRE_W-1:0]  prescaler;
    logic [IDX_W-1:0]  idx;
    logic [DW-1:0]     shadow;
    logic [DW-1:0]     display;
    logic              dwell_wrap;
    logic              frame_wrap;
    logic [3:0]        nibble;
    logic              dp;
    logic [6:0]        seg;
    logic [DIGITS-1:0] annode_d;
    logic [7:0]        cathode_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    assign dwell_wrap = (prescaler == PRE_LAST);
    assign frame_wrap = dwell_wrap && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (input_value_stb) state_next = S_ACK;
            S_ACK:     state_next = input_value_stb ? S_PENDING : S_IDLE;
            S_PENDING: if (frame_wrap) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        input_value_ack = (state == S_ACK);
        pending         = (state == S_PENDING);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
            idx       <= '0;
            shadow    <= '0;
            display   <= '0;
        end else begin
            prescaler <= dwell_wrap ? '0 : prescaler + 1'b1;
            if (dwell_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (input_value_ack && input_value_stb) shadow <= input_value[DW-1:0];
            // The shown frame only changes as the scan restarts at digit 0.
            if (frame_wrap && pending) display <= shadow;
        end
    end

    always_comb begin
        nibble = '0;
        dp     = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (k == int'(idx)) begin
                nibble = display[4*k +: 4];
                dp     = DP_MASK[k];
            end
        end
        seg = hex_to_seg(nibble);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx != '0) && ((display >> (4 * int'(idx))) == '0)) seg = '0;
`endif
        for (int k = 0; k < DIGITS; k++) begin
            annode_d[k] = (prescaler >= BLANK_LIM) && (k == int'(idx));
        end
        cathode_d = {dp, seg};
        if (ACTIVE_LOW) begin
            annode_d  = ~annode_d;
            cathode_d = ~cathode_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            output_annode  <= ANODE_OFF;
            output_cathode <= CATH_OFF;
        end else begin
            output_annode  <= annode_d;
            output_cathode <= cathode_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan (DIGITS=8, SCAN_DIV=4, BLANK_CYCLES=1, active-low); observed
// frames are scoreboarded against expected frames queued when each value is accepted.
module tb_seven_segment_scan;

    localparam logic [7:0] DP_MASK_TB = 8'h00;
    localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ_OFF = 8'hFF;
`else
    localparam logic [7:0] LZ_OFF = 8'hC0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic        stb;
    logic        ack;
    logic [7:0]  annode;
    logic [7:0]  cathode;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] cur_frame;
    logic [63:0] last_obs;
    int          wait_frames;
    int          lat;
    int          lat2;

    seven_segment_scan #(
        .DIGITS(8), .SCAN_DIV(4), .BLANK_CYCLES(1), .DP_MASK(DP_MASK_TB), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .input_value(value), .input_value_stb(stb),
        .input_value_ack(ack), .output_annode(annode), .output_cathode(cathode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_frame(input logic [31:0] v);
        logic [63:0] f;
        logic [7:0]  b;
        logic [31:0] upper;
        f = '0;
        for (int k = 0; k < 8; k++) begin
            b = {DP_MASK_TB[k], SEG_TAB[v[4*k +: 4]]};
            upper = v >> (4 * k);
`ifdef LEADING_ZERO_BLANK_EN
            if (k > 0 && upper == 32'h0) b[6:0] = 7'h00;
`else
            if (upper == 32'hFFFF_FFFF) b = b;
`endif
            f[8*k +: 8] = ~b;
        end
        return f;
    endfunction

    task automatic send(input logic [31:0] v, output int l);
        @(negedge clk);
        value = v;
        stb = 1'b1;
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!ack && l < 200);
        check("ack_seen", ack, 1'b1);
        if (ack) exp_q.push_back(model_frame(v));
        @(negedge clk);
        stb = 1'b0;
        value = $urandom;
        check("ack_pulse", ack, 1'b0);
    endtask

    task automatic sync_blank();
        int n = 0;
        while (annode == 8'hFF && n < 64) begin @(negedge clk); n++; end
        while (annode != 8'hFF && n < 128) begin @(negedge clk); n++; end
        check("sync_blank", annode, 8'hFF);
    endtask

    // Entered on a blank sample; consumes one dwell and ends on the next blank sample.
    task automatic watch_dwell(output int dig, output logic [7:0] cat);
        logic [7:0] an;
        @(negedge clk);
        an = annode;
        cat = cathode;
        dig = -1;
        for (int k = 0; k < 8; k++) if (!an[k]) dig = k;
        check("annode_onehot", $countones(~an), 1);
        repeat (2) begin
            @(negedge clk);
            check("annode_dwell", annode, an);
            check("cathode_dwell", cathode, cat);
        end
        @(negedge clk);
        check("annode_blank", annode, 8'hFF);
    endtask

    task automatic frame_done(input logic [63:0] obs);
        last_obs = obs;
        if (exp_q.size() > 0 && obs == exp_q[0]) begin
            cur_frame = exp_q.pop_front();
            wait_frames = 0;
            check("frame", obs, cur_frame);
        end else begin
            check("frame", obs, cur_frame);
            if (exp_q.size() > 0) begin
                wait_frames++;
                check("latency", (wait_frames > 2) ? 1 : 0, 0);
            end
        end
    endtask

    task automatic monitor_frames(input int n);
        int          dig;
        int          g;
        logic [7:0]  cat;
        logic [63:0] obs;
        sync_blank();
        g = 0;
        do begin
            watch_dwell(dig, cat);
            g++;
        end while (dig != 7 && g < 10);
        check("align", dig, 7);
        for (int f = 0; f < n; f++) begin
            obs = '0;
            for (int d = 0; d < 8; d++) begin
                watch_dwell(dig, cat);
                check("digit_seq", dig, d);
                obs[8*d +: 8] = cat;
            end
            frame_done(obs);
        end
    endtask

    initial begin
        rst = 1'b0;
        stb = 1'b0;
        value = '0;
        wait_frames = 0;
        last_obs = '0;
        repeat (4) @(negedge clk);
        check("reset_annode", annode, 8'hFF);
        check("reset_cathode", cathode, 8'hFF);
        check("reset_ack", ack, 1'b0);
        cur_frame = model_frame(32'h0);
        @(negedge clk);
        rst = 1'b1;
        monitor_frames(2);

        fork
            send(32'h12345678, lat);
            monitor_frames(4);
        join
        check("ack_latency", lat, 1);
        check("drain_t2", exp_q.size(), 0);
        check("digit0_code", last_obs[7:0], 8'h80);
        check("digit7_code", last_obs[63:56], 8'hF9);

        fork
            begin
                send(32'hA5A5_0C3E, lat);
                send(32'h0BEE_F719, lat2);
            end
            monitor_frames(6);
        join
        check("drain_t3", exp_q.size(), 0);
        check("backpressure_final", last_obs, model_frame(32'h0BEE_F719));

        repeat (4) begin
            fork
                begin
                    repeat ($urandom_range(0, 20)) @(negedge clk);
                    send($urandom, lat);
                end
                monitor_frames(4);
            join
            check("ack_latency_rand", lat, 1);
            check("drain_rand", exp_q.size(), 0);
        end

        fork
            send(32'h0000_0F05, lat);
            monitor_frames(4);
        join
        check("lz_digit0", last_obs[7:0], 8'h92);
        check("lz_digit1", last_obs[15:8], 8'hC0);
        check("lz_digit2", last_obs[23:16], 8'h8E);
        for (int k = 3; k < 8; k++) check("lz_upper", last_obs[8*k +: 8], LZ_OFF);

        fork
            send(32'h0, lat);
            monitor_frames(4);
        join
        check("zero_digit0", last_obs[7:0], 8'hC0);
        check("zero_digit5", last_obs[47:40], LZ_OFF);

        send(32'hDEAD_BEEF, lat);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_annode", annode, 8'hFF);
        check("midrst_cathode", cathode, 8'hFF);
        check("midrst_ack", ack, 1'b0);
        exp_q.delete();
        cur_frame = model_frame(32'h0);
        wait_frames = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        monitor_frames(3);
        check("after_rst_frame", last_obs, model_frame(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
